id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that registers decoded operands and control, then presents forwarded operands and a 4-bit operation code to the 32-bit ALU in the execute stage. It holds forwarding muxes for both operands, EX/MEM before MEM/WB priority, and a load-use hazard detector. That detector stalls decode and inserts a bubble. It sits between the register-file/decode stage and the ALU.

## Interface
Parameters:
- `DW`, 32: datapath width.
- `AW`, 5: register address width.

Ports:
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `id_valid  in  1`: decode slot holds a real instruction.
- `id_rs_data, id_rt_data  in  DW`: register-file read data.
- `id_imm  in  DW`: sign/zero-extended immediate.
- `id_rs, id_rt, id_rd  in  AW`: source and destination register numbers.
- `id_alu_op  in  4`: ALU operation code.
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL, 6 SUB, 7 SLT.
- `id_alu_src_b, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1`: decoded control.
- `flush  in  1`: squash the instruction entering this stage (branch taken).
- `exmem_reg_write  in  1`, `exmem_rd  in  AW`, `exmem_alu_res  in  DW`: EX/MEM forwarding source.
- `memwb_reg_write  in  1`, `memwb_rd  in  AW`, `memwb_wdata  in  DW`: MEM/WB forwarding source.
- `alu_a, alu_b  out  DW`: ALU operands.
- `alu_operation  out  4`: ALU operation code.
- `ex_store_data  out  DW`: forwarded rt value for stores.
- `ex_rd  out  AW`, `ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1`: registered control passed to EX/MEM.
- `stall_id  out  1`: load-use hazard. PC and IF/ID must hold.

## Operation
- Registered fields: valid, rs/rt data, imm, rs, rt, rd, alu_op, and the five control bits.
- Update priority each rising edge:
  - `rst`: all fields 0.
  - `flush` or `stall_id`: bubble. valid, reg_write, mem_read, mem_write and alu_op become 0; data fields are don't-care and are zeroed.
  - Otherwise: load from `id_*`.
- Bubble control bits are 0 even when `id_valid`=1.
- `stall_id` (combinational) = `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt)`.
- Forwarding applies per operand, to the registered rs (A) and rt (B-side/store):
  - Select EX/MEM if `exmem_reg_write & exmem_rd!=0 & exmem_rd==reg`.
  - Else select MEM/WB if `memwb_reg_write & memwb_rd!=0 & memwb_rd==reg`.
  - Else use the registered data.
- Register 0 is never forwarded.
- `alu_a` = forwarded rs.
- `alu_b` = `alu_src_b` ? imm : forwarded rt.
- `ex_store_data` = forwarded rt, regardless of `alu_src_b`.
- `alu_operation` = registered alu_op. It is 0 (AND) in a bubble, giving result 0, so the zero flag is 1. Downstream must qualify it with `ex_valid`.
- No arithmetic in this block. All widths are exact and nothing is truncated.

## Timing
- One-cycle latency, ID to EX.
- Forwarding muxes and `stall_id` are purely combinational from registered state and current inputs.
- Reset values: all outputs 0.
  - `alu_a`/`alu_b`/`ex_store_data` may become nonzero combinationally via forwarding inputs. This cannot happen for rs=rt=0.
- Load-use: `stall_id` is high for exactly one cycle per hazard. The next cycle EX holds a bubble, and the load has moved to EX/MEM. EX/MEM cannot yet supply load data, so the value is obtained from MEM/WB one cycle later.
- `flush` and `stall_id` together: a single bubble. `stall_id` still reaches the upstream stage and the upstream stage resolves the conflict (flush wins there).
- `rst` asserted mid-stream discards the in-flight instruction on that edge. `stall_id` is 0 the following cycle.
- Both forwarding sources match: EX/MEM wins.

## Structure
- Shared package/header `pipe_defs`:
  - ALU op codes (`ALU_AND`…`ALU_SLT`).
  - Forward-select encodings: `FWD_REG`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10.
  - Default widths.
- One sub-module, `forward_unit`: combinational compare logic producing the two 2-bit selects. It is instantiated once in `id_ex_stage`. Muxes and registers stay in the top.

## Test plan
- Reset, then id_valid=1, rs_data=5, rt_data=3, alu_op=6, src_b=0, no forwarding → next cycle alu_a=5, alu_b=3, alu_operation=6, ex_valid=1. Assert rst → all outputs 0 the following cycle.
- EX rs=8 registered data 1; exmem_reg_write=1, rd=8, res=0x100; memwb rd=8 wdata=0x200 → alu_a=0x100. Drop exmem_reg_write → alu_a=0x200.
- Forward to register 0: EX rs=0, exmem rd=0 with res=0xFFFF_FFFF → alu_a = registered value (0).
- Load-use: EX lw rd=9 (mem_read=1); ID id_rt=9 → stall_id=1 for one cycle; next cycle ex_valid=0, ex_reg_write=0, alu_operation=0; stall_id=0.
- flush=1 with id_valid=1, reg_write=1, mem_write=1 → next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Store: src_b=1, imm=4, rt=10, memwb rd=10 wdata=0xABCD → alu_b=4, ex_store_data=0xABCD.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared pipeline definitions: ALU op codes, forward-select encodings,
// default widths and the ID/EX control payload.
package pipe_defs;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned OPW    = 4;

  typedef enum logic [OPW-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Control bits carried from decode into execute.
  typedef struct packed {
    logic           valid;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           mem_to_reg;
    logic           alu_src_b;
    logic [OPW-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding selects: EX/MEM beats MEM/WB, register 0 never forwards.
module forward_unit
  import pipe_defs::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  output fwd_sel_e      fwd_a,
  output fwd_sel_e      fwd_b
);

  function automatic fwd_sel_e pick(input logic [AW-1:0] r,
                                    input logic mem_we, input logic [AW-1:0] mem_rd,
                                    input logic wb_we, input logic [AW-1:0] wb_rd);
    fwd_sel_e s;
    s = FWD_REG;
    if (mem_we && (mem_rd != '0) && (mem_rd == r)) begin
      s = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == r)) begin
      s = FWD_WB;
    end
    return s;
  endfunction

  always_comb begin
    fwd_a = pick(ex_rs, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    fwd_b = pick(ex_rt, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use
// hazard detection feeding the execute-stage ALU.
module id_ex_stage
  import pipe_defs::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic [3:0]    id_alu_op,
  input  logic          id_alu_src_b,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_alu_res,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_wdata,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_operation,
  output logic [DW-1:0] ex_store_data,
  output logic [AW-1:0] ex_rd,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          stall_id
);

  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [AW-1:0] rs_q, rs_d;
  logic [AW-1:0] rt_q, rt_d;
  logic [AW-1:0] rd_q, rd_d;

  fwd_sel_e      fwd_a, fwd_b;
  logic [DW-1:0] rs_fwd, rt_fwd;

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    stall_id = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
               ((rd_q == id_rs) || (rd_q == id_rt));
  end

  // Next state: load from decode, or a fully zeroed bubble on flush/stall.
  always_comb begin
    ctrl_d.valid      = id_valid;
    ctrl_d.reg_write  = id_reg_write;
    ctrl_d.mem_read   = id_mem_read;
    ctrl_d.mem_write  = id_mem_write;
    ctrl_d.mem_to_reg = id_mem_to_reg;
    ctrl_d.alu_src_b  = id_alu_src_b;
    ctrl_d.alu_op     = id_alu_op;
    rs_data_d         = id_rs_data;
    rt_data_d         = id_rt_data;
    imm_d             = id_imm;
    rs_d              = id_rs;
    rt_d              = id_rt;
    rd_d              = id_rd;
    if (flush || stall_id) begin
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  forward_unit #(.AW(AW)) u_fwd (
    .ex_rs           (rs_q),
    .ex_rt           (rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    rs_fwd = rs_data_q;
    case (fwd_a)
      FWD_MEM: rs_fwd = exmem_alu_res;
      FWD_WB:  rs_fwd = memwb_wdata;
      default: rs_fwd = rs_data_q;
    endcase
    rt_fwd = rt_data_q;
    case (fwd_b)
      FWD_MEM: rt_fwd = exmem_alu_res;
      FWD_WB:  rt_fwd = memwb_wdata;
      default: rt_fwd = rt_data_q;
    endcase
  end

  always_comb begin
    alu_a         = rs_fwd;
    alu_b         = ctrl_q.alu_src_b ? imm_q : rt_fwd;
    ex_store_data = rt_fwd;
    alu_operation = ctrl_q.alu_op;
    ex_rd         = rd_q;
    ex_valid      = ctrl_q.valid;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX outputs queued at stimulus time,
// popped and compared once the stage presents them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_b, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_res;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wdata;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_operation;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        stall_id;

  typedef struct {
    logic [31:0] a, b, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        valid, rw, mr, mw, mtr, stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src_b(id_alu_src_b), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_alu_res(exmem_alu_res), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall_id(stall_id)
  );

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] store, input logic [3:0] op,
                          input logic [4:0] rd, input logic valid, input logic rw,
                          input logic mr, input logic mw, input logic mtr,
                          input logic stall);
    exp_t e;
    e.a = a; e.b = b; e.store = store; e.op = op; e.rd = rd;
    e.valid = valid; e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr; e.stall = stall;
    exp_q.push_back(e);
  endtask

  task automatic check_ex(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "alu_a",         alu_a,                 e.a);
      cmp(tag, "alu_b",         alu_b,                 e.b);
      cmp(tag, "ex_store_data", ex_store_data,         e.store);
      cmp(tag, "alu_operation", 32'(alu_operation),    32'(e.op));
      cmp(tag, "ex_rd",         32'(ex_rd),            32'(e.rd));
      cmp(tag, "ex_valid",      32'(ex_valid),         32'(e.valid));
      cmp(tag, "ex_reg_write",  32'(ex_reg_write),     32'(e.rw));
      cmp(tag, "ex_mem_read",   32'(ex_mem_read),      32'(e.mr));
      cmp(tag, "ex_mem_write",  32'(ex_mem_write),     32'(e.mw));
      cmp(tag, "ex_mem_to_reg", 32'(ex_mem_to_reg),    32'(e.mtr));
      cmp(tag, "stall_id",      32'(stall_id),         32'(e.stall));
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] op, input logic srcb,
                        input logic rw, input logic mr, input logic mw, input logic mtr);
    id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_op = op; id_alu_src_b = srcb;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mtr;
  endtask

  task automatic clear_id();
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_alu_res = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    clear_id(); clear_fwd();

    // Reset state
    step(); step();
    push_exp('0, '0, '0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check_ex("reset");
    rst = 1'b0;

    // Plain SUB, no forwarding
    set_id(1, 32'd5, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 4'd6, 0, 1, 0, 0, 0);
    step();
    clear_id();
    push_exp(32'd5, 32'd3, 32'd3, 4'd6, 5'd3, 1, 1, 0, 0, 0, 0);
    check_ex("basic_sub");

    // Mid-stream reset discards the incoming instruction
    set_id(1, 32'd7, 32'd7, 32'd1, 5'd4, 5'd4, 5'd4, 4'd2, 0, 1, 1, 0, 1);
    rst = 1'b1;
    step();
    push_exp('0, '0, '0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check_ex("rst_mid");
    rst = 1'b0;
    clear_id();

    // EX/MEM over MEM/WB, then MEM/WB alone
    set_id(1, 32'd1, 32'd2, 32'd0, 5'd8, 5'd4, 5'd5, 4'd2, 0, 1, 0, 0, 0);
    step();
    clear_id();
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_alu_res = 32'h100;
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_wdata = 32'h200;
    #1;
    push_exp(32'h100, 32'd2, 32'd2, 4'd2, 5'd5, 1, 1, 0, 0, 0, 0);
    check_ex("fwd_mem_prio");
    exmem_reg_write = 0;
    #1;
    push_exp(32'h200, 32'd2, 32'd2, 4'd2, 5'd5, 1, 1, 0, 0, 0, 0);
    check_ex("fwd_wb");
    clear_fwd();

    // Register 0 is never forwarded
    set_id(1, 32'd0, 32'd7, 32'd0, 5'd0, 5'd0, 5'd6, 4'd1, 0, 1, 0, 0, 0);
    step();
    clear_id();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_alu_res = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_wdata = 32'hDEAD;
    #1;
    push_exp(32'd0, 32'd7, 32'd7, 4'd1, 5'd6, 1, 1, 0, 0, 0, 0);
    check_ex("fwd_r0");
    clear_fwd();

    // Load-use on rt: one stall cycle, bubble, then MEM/WB supplies load data
    set_id(1, 32'h40, 32'd0, 32'd8, 5'd2, 5'd9, 5'd9, 4'd2, 1, 1, 1, 0, 1);
    step();
    set_id(1, 32'd11, 32'd22, 32'd0, 5'd3, 5'd9, 5'd12, 4'd3, 0, 1, 0, 0, 0);
    #1;
    push_exp(32'h40, 32'd8, 32'd0, 4'd2, 5'd9, 1, 1, 1, 0, 1, 1);
    check_ex("lu_stall");
    step();
    push_exp('0, '0, '0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check_ex("lu_bubble");
    step();
    clear_id();
    memwb_reg_write = 1; memwb_rd = 5'd9; memwb_wdata = 32'h1234;
    #1;
    push_exp(32'd11, 32'h1234, 32'h1234, 4'd3, 5'd12, 1, 1, 0, 0, 0, 0);
    check_ex("lu_fwd");
    clear_fwd();

    // Load to r0 never stalls a reader of r0
    set_id(1, 32'h50, 32'd0, 32'd4, 5'd2, 5'd0, 5'd0, 4'd2, 1, 1, 1, 0, 1);
    step();
    set_id(1, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd7, 4'd2, 0, 1, 0, 0, 0);
    #1;
    push_exp(32'h50, 32'd4, 32'd0, 4'd2, 5'd0, 1, 1, 1, 0, 1, 0);
    check_ex("lu_r0_nostall");
    clear_id();

    // Flush squashes a valid store-like instruction
    set_id(1, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 4'd2, 0, 1, 0, 1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_id();
    push_exp('0, '0, '0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check_ex("flush");

    // Store: immediate on B, forwarded rt on store data
    set_id(1, 32'h1000, 32'h55, 32'd4, 5'd5, 5'd10, 5'd0, 4'd2, 1, 0, 0, 1, 0);
    step();
    clear_id();
    memwb_reg_write = 1; memwb_rd = 5'd10; memwb_wdata = 32'hABCD;
    #1;
    push_exp(32'h1000, 32'd4, 32'hABCD, 4'd2, 5'd0, 1, 0, 0, 1, 0, 0);
    check_ex("store_wb");
    exmem_reg_write = 1; exmem_rd = 5'd10; exmem_alu_res = 32'h77;
    #1;
    push_exp(32'h1000, 32'd4, 32'h77, 4'd2, 5'd0, 1, 0, 0, 1, 0, 0);
    check_ex("store_mem_prio");
    clear_fwd();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
